// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple_adder is reused once per slice,
// LSB slice first, with the inter-slice carry held in a register.

module ripple_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic c;

    always_comb begin
        c   = cin;
        sum = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int SLICES = WIDTH / 4;
    localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic              carry_q, carry_d, cout_q, cout_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [3:0]        a_slice, b_slice, rsum;
    logic              rcout;

    ripple_adder u_ripple (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (rsum),
        .cout (rcout)
    );

    // Constant-index slice mux keeps every part-select in range for any WIDTH.
    always_comb begin
        a_slice = '0;
        b_slice = '0;
        for (int s = 0; s < SLICES; s++) begin
            if (idx_q == IDX_W'(s)) begin
                a_slice = a_q[4*s +: 4];
                b_slice = b_q[4*s +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int s = 0; s < SLICES; s++) begin
                    if (idx_q == IDX_W'(s)) begin
                        sum_d[4*s +: 4] = rsum;
                    end
                end
                carry_d = rcout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = rcout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
endmodule
